// File: rtl/add_defs.sv
// Shared definitions for the bit-serial adder: FSM state encodings and a
// constant ceil-log2 helper for sizing counters.
package add_defs;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_add_bit.sv
// Combinational 1-bit full adder cell used by the serial datapath.
module full_add_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_n.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one full-adder cell.
// Result, carry and overflow appear together with a one-cycle done pulse.
module serial_add_n
    import add_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;
    logic             w_co;
    logic             w_last;

    full_add_bit u_fa (
        .a  (r_sa[0]),
        .b  (r_sb[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ADD;
            S_ADD:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1, so the inverted operand and forced carry are
    // set up once at load time and the ADD loop is mode-agnostic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                    end
                end
                S_ADD: begin
                    r_carry <= w_co;
                    r_acc   <= {w_s, r_acc[WIDTH-1:1]};
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_sum  <= {w_s, r_acc[WIDTH-1:1]};
                        r_cout <= w_co;
                        r_ovf  <= r_carry ^ w_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_ADD);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_n.sv
// Self-checking bench for serial_add_n at WIDTH = 8, 2 and 32.
module tb_serial_add_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        sub_i, cin_i;
    logic [63:0] a_i, b_i;
    logic        st2, st8, st32;

    logic        busy2, done2, cout2, ovf2;
    logic [1:0]  sum2;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        busy32, done32, cout32, ovf32;
    logic [31:0] sum32;

    int          n_asserts = 0;
    int          n_fail    = 0;

    int          sel = 8;
    logic        m_busy, m_done, m_cout, m_ovf;
    logic [63:0] m_sum;

    logic [63:0] res_sum;
    logic        res_cout, res_ovf, res_both, res_to;
    int          res_cyc, res_busy;

    always #5 clk = ~clk;

    serial_add_n #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .start(st2), .sub(sub_i), .cin(cin_i),
        .a(a_i[1:0]), .b(b_i[1:0]), .busy(busy2), .done(done2),
        .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    serial_add_n #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(st8), .sub(sub_i), .cin(cin_i),
        .a(a_i[7:0]), .b(b_i[7:0]), .busy(busy8), .done(done8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_add_n #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .start(st32), .sub(sub_i), .cin(cin_i),
        .a(a_i[31:0]), .b(b_i[31:0]), .busy(busy32), .done(done32),
        .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    always_comb begin
        m_busy = busy8;
        m_done = done8;
        m_sum  = {56'd0, sum8};
        m_cout = cout8;
        m_ovf  = ovf8;
        case (sel)
            2: begin
                m_busy = busy2; m_done = done2; m_sum = {62'd0, sum2};
                m_cout = cout2; m_ovf = ovf2;
            end
            32: begin
                m_busy = busy32; m_done = done32; m_sum = {32'd0, sum32};
                m_cout = cout32; m_ovf = ovf32;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            2:       st2  = v;
            32:      st32 = v;
            default: st8  = v;
        endcase
    endtask

    // Arithmetic reference: unsigned result/carry and signed-range overflow.
    task automatic model(input int w, input logic [63:0] av, input logic [63:0] bv,
                         input logic sv, input logic cv,
                         output logic [63:0] es, output logic ec, output logic eo);
        longint m, ua, ub, r, sa, sb, sr;
        m  = longint'(1) << w;
        ua = longint'(av) & (m - 1);
        ub = longint'(bv) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (sv) begin
            r  = ua - ub;
            ec = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub + longint'(cv);
            ec = (r >= m);
            sr = sa + sb + longint'(cv);
        end
        es = 64'(r & (m - 1));
        eo = (sr < -(m / 2)) || (sr >= m / 2);
    endtask

    // Runs one operation; on return the DUT is back in IDLE.
    task automatic do_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                         input logic sv, input logic cv, input bit glitch);
        sel   = w;
        a_i   = av; b_i = bv; sub_i = sv; cin_i = cv;
        set_start(w, 1'b1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        a_i = ~av; b_i = ~bv; sub_i = ~sv; cin_i = ~cv;
        res_cyc = 1; res_busy = 0; res_both = 1'b0; res_to = 1'b0;
        while (!m_done && !res_to) begin
            if (m_busy) res_busy++;
            if (glitch && res_cyc == 4) set_start(w, 1'b1);
            if (glitch && res_cyc == 5) set_start(w, 1'b0);
            @(posedge clk); #1;
            res_cyc++;
            if (m_done && m_busy) res_both = 1'b1;
            if (res_cyc > w + 6) res_to = 1'b1;
        end
        res_sum  = m_sum;
        res_cout = m_cout;
        res_ovf  = m_ovf;
        @(posedge clk); #1;
    endtask

    task automatic check_res(input string tag, input int w, input logic [63:0] es,
                             input logic ec, input logic eo);
        chk({tag, ".timeout"}, 64'(res_to), 64'd0);
        chk({tag, ".sum"},     res_sum, es);
        chk({tag, ".cout"},    64'(res_cout), 64'(ec));
        chk({tag, ".ovf"},     64'(res_ovf), 64'(eo));
        chk({tag, ".latency"}, 64'(res_cyc), 64'(w + 1));
        chk({tag, ".busycyc"}, 64'(res_busy), 64'(w));
        chk({tag, ".overlap"}, 64'(res_both), 64'd0);
    endtask

    task automatic rand_op(input string tag, input int w);
        logic [63:0] av, bv, es;
        logic        sv, cv, ec, eo;
        av = {$urandom, $urandom};
        bv = {$urandom, $urandom};
        sv = 1'($urandom);
        cv = 1'($urandom);
        model(w, av, bv, sv, cv, es, ec, eo);
        do_op(w, av, bv, sv, cv, 1'b0);
        check_res(tag, w, es, ec, eo);
    endtask

    logic [63:0] good_a [3];
    logic [63:0] good_b [3];
    logic        good_s [3];
    logic        good_c [3];

    initial begin
        logic [63:0] es;
        logic        ec, eo;
        int          n_done;

        rst = 1'b1;
        st2 = 1'b0; st8 = 1'b0; st32 = 1'b0;
        sub_i = 1'b0; cin_i = 1'b0; a_i = '0; b_i = '0;
        #2;
        chk("rst.busy8",  64'(busy8),  64'd0);
        chk("rst.done8",  64'(done8),  64'd0);
        chk("rst.sum8",   64'(sum8),   64'd0);
        chk("rst.cout8",  64'(cout8),  64'd0);
        chk("rst.ovf8",   64'(ovf8),   64'd0);
        chk("rst.sum32",  64'(sum32),  64'd0);
        chk("rst.busy2",  64'(busy2),  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(8, 64'h5A, 64'h3C, 1'b0, 1'b0, 1'b0);
        check_res("add", 8, 64'h96, 1'b0, 1'b1);
        do_op(8, 64'hFF, 64'h01, 1'b0, 1'b0, 1'b0);
        check_res("wrap", 8, 64'h00, 1'b1, 1'b0);
        do_op(8, 64'hFF, 64'h01, 1'b0, 1'b1, 1'b0);
        check_res("wrap_cin", 8, 64'h01, 1'b1, 1'b0);
        do_op(8, 64'h10, 64'h20, 1'b1, 1'b0, 1'b0);
        check_res("sub_borrow", 8, 64'hF0, 1'b0, 1'b0);
        do_op(8, 64'h80, 64'h01, 1'b1, 1'b1, 1'b0);
        check_res("sub_ovf", 8, 64'h7F, 1'b1, 1'b1);

        // Start pulse during ADD must not disturb the result or add a done.
        do_op(8, 64'h33, 64'h44, 1'b0, 1'b1, 1'b1);
        check_res("glitch", 8, 64'h78, 1'b0, 1'b0);
        n_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) n_done++;
        end
        chk("glitch.extra_done", 64'(n_done), 64'd0);

        // start held high: only operands present at IDLE edges are used.
        for (int i = 0; i < 3; i++) begin
            good_a[i] = 64'($urandom_range(0, 255));
            good_b[i] = 64'($urandom_range(0, 255));
            good_s[i] = 1'($urandom);
            good_c[i] = 1'($urandom);
        end
        sel = 8; n_done = 0; st8 = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k % 10 == 0) begin
                a_i = good_a[k / 10]; b_i = good_b[k / 10];
                sub_i = good_s[k / 10]; cin_i = good_c[k / 10];
            end else begin
                a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom};
                sub_i = 1'($urandom); cin_i = 1'($urandom);
            end
            @(posedge clk); #1;
            if (done8) begin
                if (n_done < 3) begin
                    model(8, good_a[n_done], good_b[n_done], good_s[n_done],
                          good_c[n_done], es, ec, eo);
                    chk("b2b.edge", 64'(k), 64'(10 * n_done + 8));
                    chk("b2b.sum",  64'(sum8), es);
                    chk("b2b.cout", 64'(cout8), 64'(ec));
                    chk("b2b.ovf",  64'(ovf8), 64'(eo));
                end
                n_done++;
            end
        end
        st8 = 1'b0;
        chk("b2b.count", 64'(n_done), 64'd3);

        // Asynchronous reset in the middle of an operation.
        sel = 8;
        a_i = 64'h21; b_i = 64'h12; sub_i = 1'b0; cin_i = 1'b0;
        st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("prerst.busy", 64'(busy8), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst.busy", 64'(busy8), 64'd0);
        chk("midrst.done", 64'(done8), 64'd0);
        chk("midrst.sum",  64'(sum8),  64'd0);
        chk("midrst.cout", 64'(cout8), 64'd0);
        chk("midrst.ovf",  64'(ovf8),  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) n_done++;
        end
        chk("midrst.no_done", 64'(n_done), 64'd0);
        do_op(8, 64'h01, 64'h01, 1'b0, 1'b0, 1'b0);
        check_res("postrst", 8, 64'h02, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) rand_op("rnd_w2", 2);
        for (int i = 0; i < 10; i++) rand_op("rnd_w8", 8);
        for (int i = 0; i < 20; i++) rand_op("rnd_w32", 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
